// File: rtl/rf_cpi_sched.sv
// rtl/rf_cpi_sched.sv - CPI timing and frequency-hop sequencer for the RF control path
module rf_cpi_sched #(
  parameter int FREQ_W    = 16,
  parameter int TBL_DEPTH = 16,
  parameter int ADDR_W    = 4,
  parameter int CNT_W     = 24,
  parameter int PRE_LEAD  = 10,
  parameter int PULSE_W   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_cfg_we,
  input  logic [ADDR_W-1:0]   i_cfg_addr,
  input  logic [FREQ_W-1:0]   i_cfg_data,
  input  logic [ADDR_W:0]     i_tbl_len,
  input  logic [CNT_W-1:0]    i_cpi_period,
  input  logic [CNT_W-1:0]    i_tx_len,
  input  logic                i_init,
  input  logic                i_stop,
  output logic [FREQ_W-1:0]   o_rf_freq,
  output logic                o_rf_freq_vld,
  output logic                o_pre_cpi,
  output logic                o_cpi,
  output logic                o_tx_over_flag,
  output logic                o_busy,
  output logic [15:0]         o_cpi_cnt,
  output logic                o_cfg_err
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN} state_t;

  localparam logic PULSE_OK = (PULSE_W <= PRE_LEAD);

  logic [FREQ_W-1:0] r_tbl [TBL_DEPTH];

  state_t            r_state, w_state;
  logic [CNT_W-1:0]  r_cnt, w_cnt;
  logic [ADDR_W-1:0] r_idx, w_idx;
  logic [ADDR_W:0]   r_len, w_len;
  logic [CNT_W-1:0]  r_period, w_period;
  logic [CNT_W-1:0]  r_tx, w_tx;
  logic              r_stop_pend, w_stop_pend;
  logic              r_cpi_seen, w_cpi_seen;
  logic [FREQ_W-1:0] r_freq, w_freq;
  logic              r_vld, w_vld;
  logic              r_pre, w_pre;
  logic              r_cpi, w_cpi;
  logic              r_txo, w_txo;
  logic              r_busy, w_busy;
  logic [15:0]       r_cpi_cnt, w_cpi_cnt;
  logic              r_err, w_err;

  logic              w_len_ok, w_tx_ok, w_p_ok, w_cfg_ok;
  logic [CNT_W-1:0]  w_pre_lo, w_pre_hi, w_cnt_nx;
  logic [ADDR_W-1:0] w_idx_nx;

  // Table has no reset: contents are undefined until written.
  always_ff @(posedge clk) begin
    if (i_cfg_we) r_tbl[i_cfg_addr] <= i_cfg_data;
  end

  assign w_len_ok = (i_tbl_len != '0) && (i_tbl_len <= (ADDR_W+1)'(TBL_DEPTH));
  assign w_tx_ok  = (i_tx_len >= CNT_W'(PULSE_W));
  assign w_p_ok   = ({2'b00, i_tx_len} + (CNT_W+2)'(PRE_LEAD + 2)) <= {2'b00, i_cpi_period};
  assign w_cfg_ok = w_len_ok && w_tx_ok && w_p_ok && PULSE_OK;

  assign w_pre_lo = r_period - CNT_W'(PRE_LEAD);
  assign w_pre_hi = w_pre_lo + CNT_W'(PULSE_W - 1);
  assign w_cnt_nx = (r_cnt == r_period - CNT_W'(1)) ? '0 : r_cnt + CNT_W'(1);
  assign w_idx_nx = ({1'b0, r_idx} == r_len - (ADDR_W+1)'(1)) ? '0 : r_idx + ADDR_W'(1);

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_idx       = r_idx;
    w_len       = r_len;
    w_period    = r_period;
    w_tx        = r_tx;
    w_stop_pend = r_stop_pend;
    w_cpi_seen  = r_cpi_seen;
    w_freq      = r_freq;
    w_vld       = 1'b0;
    w_pre       = 1'b0;
    w_cpi       = 1'b0;
    w_txo       = 1'b0;
    w_busy      = (r_state != S_IDLE);
    w_cpi_cnt   = r_cpi_cnt;
    w_err       = r_err;

    case (r_state)
      S_IDLE: begin
        w_stop_pend = 1'b0;
        w_cpi_seen  = 1'b0;
        if (i_init && !i_stop) begin
          if (w_cfg_ok) begin
            w_state   = S_START;
            w_len     = i_tbl_len;
            w_period  = i_cpi_period;
            w_tx      = i_tx_len;
            w_idx     = '0;
            w_cnt     = i_cpi_period - CNT_W'(PRE_LEAD + 1);
            w_cpi_cnt = '0;
            w_err     = 1'b0;
          end else begin
            w_err = 1'b1;
          end
        end
      end

      S_START: begin
        if (i_stop) begin
          w_state = S_IDLE;
        end else begin
          w_freq  = r_tbl[0];
          w_vld   = 1'b1;
          w_cnt   = r_cnt + CNT_W'(1);
          w_state = S_RUN;
        end
      end

      S_RUN: begin
        // Before the first CPI edge a stop aborts at once; afterwards it waits for TX.
        if (i_stop && !r_cpi_seen) begin
          w_state = S_IDLE;
        end else begin
          w_cnt = w_cnt_nx;
          w_pre = (r_cnt >= w_pre_lo) && (r_cnt <= w_pre_hi);
          w_cpi = (r_cnt < CNT_W'(PULSE_W));
          if (r_cnt == '0) begin
            w_cpi_cnt  = r_cpi_cnt + 16'd1;
            w_cpi_seen = 1'b1;
          end
          if (i_stop) w_stop_pend = 1'b1;
          if (r_cnt == r_tx) begin
            w_txo = 1'b1;
            if (r_stop_pend) w_state = S_IDLE;
          end
          if (r_cnt == r_tx + CNT_W'(1)) begin
            w_idx  = w_idx_nx;
            w_freq = r_tbl[w_idx_nx];
            w_vld  = 1'b1;
          end
        end
      end

      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_len       <= '0;
      r_period    <= '0;
      r_tx        <= '0;
      r_stop_pend <= 1'b0;
      r_cpi_seen  <= 1'b0;
      r_freq      <= '0;
      r_vld       <= 1'b0;
      r_pre       <= 1'b0;
      r_cpi       <= 1'b0;
      r_txo       <= 1'b0;
      r_busy      <= 1'b0;
      r_cpi_cnt   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_idx       <= w_idx;
      r_len       <= w_len;
      r_period    <= w_period;
      r_tx        <= w_tx;
      r_stop_pend <= w_stop_pend;
      r_cpi_seen  <= w_cpi_seen;
      r_freq      <= w_freq;
      r_vld       <= w_vld;
      r_pre       <= w_pre;
      r_cpi       <= w_cpi;
      r_txo       <= w_txo;
      r_busy      <= w_busy;
      r_cpi_cnt   <= w_cpi_cnt;
      r_err       <= w_err;
    end
  end

  assign o_rf_freq      = r_freq;
  assign o_rf_freq_vld  = r_vld;
  assign o_pre_cpi      = r_pre;
  assign o_cpi          = r_cpi;
  assign o_tx_over_flag = r_txo;
  assign o_busy         = r_busy;
  assign o_cpi_cnt      = r_cpi_cnt;
  assign o_cfg_err      = r_err;

endmodule

// File: tb/tb_rf_cpi_sched.sv
// tb/tb_rf_cpi_sched.sv - directed self-checking bench for rf_cpi_sched
module tb_rf_cpi_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_cfg_we = 1'b0;
  logic [3:0]  i_cfg_addr = '0;
  logic [15:0] i_cfg_data = '0;
  logic [4:0]  i_tbl_len = '0;
  logic [23:0] i_cpi_period = '0;
  logic [23:0] i_tx_len = '0;
  logic        i_init = 1'b0;
  logic        i_stop = 1'b0;
  logic [15:0] o_rf_freq;
  logic        o_rf_freq_vld;
  logic        o_pre_cpi;
  logic        o_cpi;
  logic        o_tx_over_flag;
  logic        o_busy;
  logic [15:0] o_cpi_cnt;
  logic        o_cfg_err;

  int n_cmp = 0;
  int n_bad = 0;
  int t = 0;

  always #5 clk = ~clk;

  rf_cpi_sched dut (
    .clk(clk), .rst_n(rst_n),
    .i_cfg_we(i_cfg_we), .i_cfg_addr(i_cfg_addr), .i_cfg_data(i_cfg_data),
    .i_tbl_len(i_tbl_len), .i_cpi_period(i_cpi_period), .i_tx_len(i_tx_len),
    .i_init(i_init), .i_stop(i_stop),
    .o_rf_freq(o_rf_freq), .o_rf_freq_vld(o_rf_freq_vld), .o_pre_cpi(o_pre_cpi),
    .o_cpi(o_cpi), .o_tx_over_flag(o_tx_over_flag), .o_busy(o_busy),
    .o_cpi_cnt(o_cpi_cnt), .o_cfg_err(o_cfg_err)
  );

  // t = number of edges since the edge that accepted i_init; sampling is 1ns after that edge.
  task automatic adv_to(input int target);
    while (t < target) begin
      @(posedge clk); #1;
      t++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wr_tbl(input logic [3:0] a, input logic [15:0] d);
    i_cfg_we = 1'b1; i_cfg_addr = a; i_cfg_data = d;
    @(posedge clk); #1;
    i_cfg_we = 1'b0;
  endtask

  task automatic do_init(input logic [4:0] len, input logic [23:0] p, input logic [23:0] tx, input logic stp);
    i_tbl_len = len; i_cpi_period = p; i_tx_len = tx; i_init = 1'b1; i_stop = stp;
    @(posedge clk); #1;
    i_init = 1'b0; i_stop = 1'b0;
    t = 0;
  endtask

  task automatic load_std_table();
    wr_tbl(4'd0, 16'h1000);
    wr_tbl(4'd1, 16'h2000);
    wr_tbl(4'd2, 16'h3000);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp++; if ({o_rf_freq, o_rf_freq_vld, o_pre_cpi, o_cpi, o_tx_over_flag, o_busy, o_cpi_cnt, o_cfg_err} !== 39'd0) begin n_bad++; $display("FAIL reset_outputs actual=%h required=0", {o_rf_freq, o_rf_freq_vld, o_pre_cpi, o_cpi, o_tx_over_flag, o_busy, o_cpi_cnt, o_cfg_err}); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy actual=%b required=0", o_busy); end
  endtask

  task automatic test_basic();
    load_std_table();
    do_init(5'd3, 24'd100, 24'd40, 1'b0);
    adv_to(1);
    n_cmp++; if (o_rf_freq_vld !== 1'b1 || o_rf_freq !== 16'h1000) begin n_bad++; $display("FAIL basic_first_strobe actual=%b/%h required=1/1000", o_rf_freq_vld, o_rf_freq); end
    n_cmp++; if (o_pre_cpi !== 1'b0) begin n_bad++; $display("FAIL basic_pre_k1 actual=%b required=0", o_pre_cpi); end
    adv_to(2);
    n_cmp++; if (o_pre_cpi !== 1'b1 || o_rf_freq_vld !== 1'b0 || o_busy !== 1'b1) begin n_bad++; $display("FAIL basic_pre_k2 actual=%b/%b/%b required=1/0/1", o_pre_cpi, o_rf_freq_vld, o_busy); end
    adv_to(5);
    n_cmp++; if (o_pre_cpi !== 1'b1) begin n_bad++; $display("FAIL basic_pre_k5 actual=%b required=1", o_pre_cpi); end
    adv_to(6);
    n_cmp++; if (o_pre_cpi !== 1'b0) begin n_bad++; $display("FAIL basic_pre_k6 actual=%b required=0", o_pre_cpi); end
    adv_to(11);
    n_cmp++; if (o_cpi !== 1'b0) begin n_bad++; $display("FAIL basic_cpi_k11 actual=%b required=0", o_cpi); end
    adv_to(12);
    n_cmp++; if (o_cpi !== 1'b1 || o_cpi_cnt !== 16'd1) begin n_bad++; $display("FAIL basic_cpi_k12 actual=%b/%0d required=1/1", o_cpi, o_cpi_cnt); end
    adv_to(15);
    n_cmp++; if (o_cpi !== 1'b1) begin n_bad++; $display("FAIL basic_cpi_k15 actual=%b required=1", o_cpi); end
    adv_to(16);
    n_cmp++; if (o_cpi !== 1'b0) begin n_bad++; $display("FAIL basic_cpi_k16 actual=%b required=0", o_cpi); end
    adv_to(51);
    n_cmp++; if (o_tx_over_flag !== 1'b0) begin n_bad++; $display("FAIL basic_tx_k51 actual=%b required=0", o_tx_over_flag); end
    adv_to(52);
    n_cmp++; if (o_tx_over_flag !== 1'b1 || o_rf_freq !== 16'h1000) begin n_bad++; $display("FAIL basic_tx_k52 actual=%b/%h required=1/1000", o_tx_over_flag, o_rf_freq); end
    adv_to(53);
    n_cmp++; if (o_tx_over_flag !== 1'b0 || o_rf_freq_vld !== 1'b1 || o_rf_freq !== 16'h2000) begin n_bad++; $display("FAIL basic_strobe_k53 actual=%b/%b/%h required=0/1/2000", o_tx_over_flag, o_rf_freq_vld, o_rf_freq); end
    adv_to(54);
    n_cmp++; if (o_rf_freq_vld !== 1'b0 || o_rf_freq !== 16'h2000) begin n_bad++; $display("FAIL basic_hold_k54 actual=%b/%h required=0/2000", o_rf_freq_vld, o_rf_freq); end
    adv_to(101);
    n_cmp++; if (o_pre_cpi !== 1'b0) begin n_bad++; $display("FAIL basic_pre_k101 actual=%b required=0", o_pre_cpi); end
    adv_to(102);
    n_cmp++; if (o_pre_cpi !== 1'b1) begin n_bad++; $display("FAIL basic_pre_k102 actual=%b required=1", o_pre_cpi); end
    adv_to(112);
    n_cmp++; if (o_cpi !== 1'b1 || o_cpi_cnt !== 16'd2) begin n_bad++; $display("FAIL basic_cpi_k112 actual=%b/%0d required=1/2", o_cpi, o_cpi_cnt); end
  endtask

  task automatic test_wraparound();
    adv_to(153);
    n_cmp++; if (o_rf_freq_vld !== 1'b1 || o_rf_freq !== 16'h3000) begin n_bad++; $display("FAIL wrap_strobe3 actual=%b/%h required=1/3000", o_rf_freq_vld, o_rf_freq); end
    adv_to(253);
    n_cmp++; if (o_rf_freq_vld !== 1'b1 || o_rf_freq !== 16'h1000) begin n_bad++; $display("FAIL wrap_strobe4 actual=%b/%h required=1/1000", o_rf_freq_vld, o_rf_freq); end
    adv_to(311);
    n_cmp++; if (o_cpi_cnt !== 16'd3) begin n_bad++; $display("FAIL wrap_cnt_k311 actual=%0d required=3", o_cpi_cnt); end
    adv_to(312);
    n_cmp++; if (o_cpi_cnt !== 16'd4) begin n_bad++; $display("FAIL wrap_cnt_k312 actual=%0d required=4", o_cpi_cnt); end
    do_reset();
  endtask

  task automatic test_stop_pending();
    do_init(5'd3, 24'd100, 24'd40, 1'b0);
    adv_to(59);
    i_stop = 1'b1;
    adv_to(60);
    i_stop = 1'b0;
    adv_to(102);
    n_cmp++; if (o_pre_cpi !== 1'b1) begin n_bad++; $display("FAIL stop_pre_k102 actual=%b required=1", o_pre_cpi); end
    adv_to(112);
    n_cmp++; if (o_cpi !== 1'b1) begin n_bad++; $display("FAIL stop_cpi_k112 actual=%b required=1", o_cpi); end
    adv_to(152);
    n_cmp++; if (o_tx_over_flag !== 1'b1 || o_busy !== 1'b1) begin n_bad++; $display("FAIL stop_tx_k152 actual=%b/%b required=1/1", o_tx_over_flag, o_busy); end
    adv_to(153);
    n_cmp++; if (o_busy !== 1'b0 || o_rf_freq_vld !== 1'b0) begin n_bad++; $display("FAIL stop_idle_k153 actual=%b/%b required=0/0", o_busy, o_rf_freq_vld); end
    adv_to(202);
    n_cmp++; if (o_pre_cpi !== 1'b0 || o_busy !== 1'b0) begin n_bad++; $display("FAIL stop_nopre_k202 actual=%b/%b required=0/0", o_pre_cpi, o_busy); end
  endtask

  task automatic test_stop_early();
    logic seen_cpi;
    do_init(5'd3, 24'd100, 24'd40, 1'b0);
    adv_to(4);
    i_stop = 1'b1;
    adv_to(5);
    i_stop = 1'b0;
    n_cmp++; if (o_busy !== 1'b1) begin n_bad++; $display("FAIL early_busy_k5 actual=%b required=1", o_busy); end
    adv_to(6);
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL early_idle_k6 actual=%b required=0", o_busy); end
    seen_cpi = 1'b0;
    while (t < 30) begin
      adv_to(t + 1);
      if (o_cpi) seen_cpi = 1'b1;
    end
    n_cmp++; if (seen_cpi !== 1'b0) begin n_bad++; $display("FAIL early_no_cpi actual=%b required=0", seen_cpi); end
  endtask

  task automatic test_cfg_err();
    do_init(5'd3, 24'd50, 24'd40, 1'b0);
    adv_to(1);
    n_cmp++; if (o_cfg_err !== 1'b1 || o_busy !== 1'b0) begin n_bad++; $display("FAIL cfg_err_set actual=%b/%b required=1/0", o_cfg_err, o_busy); end
    adv_to(8);
    n_cmp++; if (o_busy !== 1'b0 || o_rf_freq_vld !== 1'b0 || o_cfg_err !== 1'b1) begin n_bad++; $display("FAIL cfg_err_idle actual=%b/%b/%b required=0/0/1", o_busy, o_rf_freq_vld, o_cfg_err); end
    do_init(5'd0, 24'd100, 24'd40, 1'b0);
    adv_to(2);
    n_cmp++; if (o_cfg_err !== 1'b1 || o_busy !== 1'b0) begin n_bad++; $display("FAIL cfg_err_len0 actual=%b/%b required=1/0", o_cfg_err, o_busy); end
    do_init(5'd3, 24'd52, 24'd40, 1'b0);
    adv_to(1);
    n_cmp++; if (o_cfg_err !== 1'b0 || o_rf_freq_vld !== 1'b1) begin n_bad++; $display("FAIL cfg_err_clear actual=%b/%b required=0/1", o_cfg_err, o_rf_freq_vld); end
    adv_to(2);
    n_cmp++; if (o_busy !== 1'b1) begin n_bad++; $display("FAIL cfg_err_run actual=%b required=1", o_busy); end
    do_reset();
  endtask

  task automatic test_live_write();
    do_init(5'd3, 24'd100, 24'd40, 1'b0);
    adv_to(19);
    i_cfg_we = 1'b1; i_cfg_addr = 4'd2; i_cfg_data = 16'h5555;
    adv_to(20);
    i_cfg_we = 1'b0;
    adv_to(53);
    n_cmp++; if (o_rf_freq_vld !== 1'b1 || o_rf_freq !== 16'h2000) begin n_bad++; $display("FAIL live_strobe2 actual=%b/%h required=1/2000", o_rf_freq_vld, o_rf_freq); end
    adv_to(153);
    n_cmp++; if (o_rf_freq_vld !== 1'b1 || o_rf_freq !== 16'h5555) begin n_bad++; $display("FAIL live_strobe3 actual=%b/%h required=1/5555", o_rf_freq_vld, o_rf_freq); end
    do_reset();
    wr_tbl(4'd2, 16'h3000);
  endtask

  task automatic test_reset_mid();
    do_init(5'd3, 24'd100, 24'd40, 1'b0);
    adv_to(90);
    n_cmp++; if (o_busy !== 1'b1 || o_cpi_cnt !== 16'd1) begin n_bad++; $display("FAIL rstmid_pre actual=%b/%0d required=1/1", o_busy, o_cpi_cnt); end
    rst_n = 1'b0;
    adv_to(91);
    n_cmp++; if ({o_rf_freq, o_rf_freq_vld, o_pre_cpi, o_cpi, o_tx_over_flag, o_busy, o_cpi_cnt, o_cfg_err} !== 39'd0) begin n_bad++; $display("FAIL rstmid_zero actual=%h required=0", {o_rf_freq, o_rf_freq_vld, o_pre_cpi, o_cpi, o_tx_over_flag, o_busy, o_cpi_cnt, o_cfg_err}); end
    rst_n = 1'b1;
    adv_to(93);
    do_init(5'd3, 24'd100, 24'd40, 1'b0);
    adv_to(1);
    n_cmp++; if (o_rf_freq_vld !== 1'b1 || o_rf_freq !== 16'h1000) begin n_bad++; $display("FAIL rstmid_restart actual=%b/%h required=1/1000", o_rf_freq_vld, o_rf_freq); end
    adv_to(12);
    n_cmp++; if (o_cpi !== 1'b1 || o_cpi_cnt !== 16'd1) begin n_bad++; $display("FAIL rstmid_cpi actual=%b/%0d required=1/1", o_cpi, o_cpi_cnt); end
    do_reset();
  endtask

  task automatic test_init_stop_same();
    logic any_act;
    do_init(5'd3, 24'd100, 24'd40, 1'b1);
    any_act = 1'b0;
    while (t < 20) begin
      adv_to(t + 1);
      if (o_busy || o_rf_freq_vld || o_pre_cpi || o_cpi) any_act = 1'b1;
    end
    n_cmp++; if (any_act !== 1'b0) begin n_bad++; $display("FAIL init_stop_activity actual=%b required=0", any_act); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wraparound();
    test_stop_pending();
    test_stop_early();
    test_cfg_err();
    test_live_write();
    test_reset_mid();
    test_init_stop_same();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
